matrix_dac_cfg: RTL and testbench

- Parametrised digital control front-end for the matrix bias DAC bank.
- Holds one binary code per DAC in double-buffered shadow/active registers and drives the thermometer-coded SET buses into the analogue DAC block.
- Adds a per-DAC code-ramp mode for DAC characterisation and threshold scans. The previous generation had fixed-width SET buses driven statically from outside.

---
 rtl/matrix_dac_pkg.sv | 26 ++
 rtl/therm_dec.sv | 16 +
 rtl/matrix_dac_cfg.sv | 153 +++++++++++++++
 tb/tb_matrix_dac_cfg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_dac_pkg.sv
// Shared definitions for the matrix bias DAC control front-end.
package matrix_dac_pkg;

  // DAC bank ordering on the SET bus
  localparam int IBIAS    = 0;
  localparam int ICASN    = 1;
  localparam int IDB      = 2;
  localparam int IRESET   = 3;
  localparam int ITHR     = 4;
  localparam int VCASN    = 5;
  localparam int VCLIP    = 6;
  localparam int VH       = 7;
  localparam int VL       = 8;
  localparam int VRESET_D = 9;
  localparam int VRESET_P = 10;

  localparam int NUM_DAC_DEF  = VRESET_P + 1;
  localparam int DAC_RST_CODE = 64;

  typedef enum logic [1:0] {
    RAMP_IDLE,
    RAMP_HOLD,
    RAMP_STEP
  } ramp_state_t;

endpackage

// File: rtl/therm_dec.sv
// Binary to thermometer decoder for one DAC slice.
module therm_dec #(
  parameter int CODE_W  = 7,
  parameter int THERM_W = 2**CODE_W
) (
  input  logic [CODE_W-1:0]  code,
  output logic [THERM_W-1:0] therm
);

  // level i is on for every i up to and including the code (code 0 keeps bit 0 on)
  always_comb begin
    therm = '0;
    for (int i = 0; i < THERM_W; i++) therm[i] = (CODE_W'(i) <= code);
  end

endmodule

// File: rtl/matrix_dac_cfg.sv
// Matrix bias DAC front-end: shadow/active code registers, per-DAC code ramp,
// registered thermometer SET bus.
module matrix_dac_cfg
  import matrix_dac_pkg::*;
#(
  parameter int N_DAC    = NUM_DAC_DEF,
  parameter int CODE_W   = 7,
  parameter int THERM_W  = 2**CODE_W,
  parameter int DWELL_W  = 16,
  parameter int RST_CODE = DAC_RST_CODE,
  parameter int ADDR_W   = $clog2(N_DAC)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     cfg_wr,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [CODE_W-1:0]        cfg_wdata,
  input  logic                     cfg_apply,
  output logic [CODE_W-1:0]        cfg_rdata,
  output logic                     cfg_err,
  input  logic                     ramp_start,
  input  logic                     ramp_abort,
  input  logic [ADDR_W-1:0]        ramp_sel,
  input  logic [CODE_W-1:0]        ramp_lo,
  input  logic [CODE_W-1:0]        ramp_hi,
  input  logic [CODE_W-1:0]        ramp_step,
  input  logic [DWELL_W-1:0]       ramp_dwell,
  output logic                     ramp_busy,
  output logic                     ramp_strobe,
  output logic [CODE_W-1:0]        ramp_code,
  output logic                     ramp_done,
  output logic [N_DAC*THERM_W-1:0] SET_BUS
);

  localparam logic [CODE_W-1:0] RST_C   = CODE_W'(RST_CODE);
  localparam logic [ADDR_W:0]   N_DAC_L = (ADDR_W+1)'(N_DAC);

  function automatic logic [THERM_W-1:0] therm_const(input logic [CODE_W-1:0] c);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W; i++) t[i] = (CODE_W'(i) <= c);
    return t;
  endfunction

  localparam logic [THERM_W-1:0] RST_THERM = therm_const(RST_C);

  logic [N_DAC-1:0][CODE_W-1:0]  shadow_q, active_q, eff;
  logic [N_DAC-1:0][THERM_W-1:0] dec, set_q;

  ramp_state_t        state_q;
  logic [CODE_W-1:0]  cnt_q, hi_q, step_q;
  logic [ADDR_W-1:0]  sel_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt_q;
  logic [CODE_W:0]    nxt;
  logic               busy, addr_ok, ramp_ok;

  assign busy    = (state_q != RAMP_IDLE);
  assign addr_ok = ({1'b0, cfg_addr} < N_DAC_L);
  assign ramp_ok = ({1'b0, ramp_sel} < N_DAC_L) && (ramp_step != '0) && (ramp_lo <= ramp_hi);
  // one extra bit so a step past the top code is seen instead of wrapping
  assign nxt     = {1'b0, cnt_q} + {1'b0, step_q};

  assign ramp_busy = busy;
  assign ramp_code = cnt_q;
  assign SET_BUS   = set_q;

  // shadow takes writes; apply copies the pre-write shadow into active
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shadow_q <= {N_DAC{RST_C}};
      active_q <= {N_DAC{RST_C}};
    end else begin
      if (cfg_wr && addr_ok) shadow_q[cfg_addr] <= cfg_wdata;
      if (cfg_apply)         active_q <= shadow_q;
    end
  end

  // readback and error pulse for bad writes or rejected ramp requests
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_rdata <= addr_ok ? shadow_q[cfg_addr] : '0;
      cfg_err   <= (cfg_wr && !addr_ok) || (ramp_start && !busy && !ramp_ok);
    end
  end

  // ramped DAC follows the counter while busy, every other DAC its active code
  for (genvar d = 0; d < N_DAC; d++) begin : g_dac
    assign eff[d] = (busy && sel_q == ADDR_W'(d)) ? cnt_q : active_q[d];
    therm_dec #(.CODE_W(CODE_W), .THERM_W(THERM_W)) u_dec (.code(eff[d]), .therm(dec[d]));
  end

  // SET bus is retimed so the analogue side sees glitch-free levels
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) set_q <= {N_DAC{RST_THERM}};
    else       set_q <= dec;
  end

  // ramp sequencer: hold each code dwell+1 cycles, then step until past hi
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RAMP_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      ramp_strobe <= 1'b0;
      ramp_done   <= 1'b0;
    end else begin
      ramp_strobe <= 1'b0;
      ramp_done   <= 1'b0;
      case (state_q)
        RAMP_IDLE: if (ramp_start && ramp_ok) begin
          state_q     <= RAMP_HOLD;
          sel_q       <= ramp_sel;
          hi_q        <= ramp_hi;
          step_q      <= ramp_step;
          dwell_q     <= ramp_dwell;
          cnt_q       <= ramp_lo;
          dwell_cnt_q <= '0;
          ramp_strobe <= 1'b1;
        end
        RAMP_HOLD: begin
          if (ramp_abort) begin
            state_q   <= RAMP_IDLE;
            ramp_done <= 1'b1;
          end else if (dwell_cnt_q == dwell_q) begin
            state_q <= RAMP_STEP;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
          end
        end
        RAMP_STEP: begin
          if (ramp_abort || nxt > {1'b0, hi_q}) begin
            state_q   <= RAMP_IDLE;
            ramp_done <= 1'b1;
          end else begin
            state_q     <= RAMP_HOLD;
            cnt_q       <= nxt[CODE_W-1:0];
            dwell_cnt_q <= '0;
            ramp_strobe <= 1'b1;
          end
        end
        default: state_q <= RAMP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_dac_cfg.sv
// Directed bench for matrix_dac_cfg: config table plus ramp/abort/reset sequences.
module tb_matrix_dac_cfg;

  localparam int ND = 11;
  localparam int TW = 128;

  logic            CLK, nRST;
  logic            cfg_wr, cfg_apply, cfg_err;
  logic [3:0]      cfg_addr;
  logic [6:0]      cfg_wdata, cfg_rdata;
  logic            ramp_start, ramp_abort, ramp_busy, ramp_strobe, ramp_done;
  logic [3:0]      ramp_sel;
  logic [6:0]      ramp_lo, ramp_hi, ramp_step, ramp_code;
  logic [15:0]     ramp_dwell;
  logic [ND*TW-1:0] SET_BUS;

  matrix_dac_cfg dut (
    .CLK(CLK), .nRST(nRST),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_apply(cfg_apply),
    .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .ramp_start(ramp_start), .ramp_abort(ramp_abort), .ramp_sel(ramp_sel),
    .ramp_lo(ramp_lo), .ramp_hi(ramp_hi), .ramp_step(ramp_step), .ramp_dwell(ramp_dwell),
    .ramp_busy(ramp_busy), .ramp_strobe(ramp_strobe), .ramp_code(ramp_code),
    .ramp_done(ramp_done), .SET_BUS(SET_BUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [6:0] wdata;
    logic [6:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t tbl[10];

  // ramp run results
  int         r_ns, r_busy, r_done, r_err, r_abort_cyc, r_done_cyc;
  bit         r_to;
  logic [6:0] r_codes[$];

  function automatic logic [TW-1:0] therm(input int c);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i++) if (i <= c) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [TW-1:0] slice(input int d);
    return SET_BUS[d*TW +: TW];
  endfunction

  function automatic logic [6:0] code_at(input int i);
    if (i < r_codes.size()) return r_codes[i];
    return 7'bx;
  endfunction

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_ramp(input logic [3:0] sel, input logic [6:0] lo, input logic [6:0] hi,
                          input logic [6:0] st, input logic [15:0] dw, input int abort_at,
                          input bit mid_apply, input bit restart);
    logic       prev_s;
    logic [6:0] prev_c;
    r_ns = 0; r_busy = 0; r_done = 0; r_err = 0;
    r_abort_cyc = -1; r_done_cyc = -1; r_to = 1'b1;
    r_codes.delete();
    prev_s = 1'b0; prev_c = '0;
    @(negedge CLK);
    ramp_sel = sel; ramp_lo = lo; ramp_hi = hi; ramp_step = st; ramp_dwell = dw;
    ramp_start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      ramp_start = 1'b0; ramp_abort = 1'b0; cfg_wr = 1'b0; cfg_apply = 1'b0;
      if (prev_s) chk($sformatf("hold_slice%0d_code%0d", sel, prev_c), slice(sel), therm(prev_c));
      prev_s = ramp_strobe;
      prev_c = ramp_code;
      if (ramp_busy) r_busy++;
      if (cfg_err)   r_err++;
      if (ramp_strobe) begin
        r_ns++;
        r_codes.push_back(ramp_code);
        if (r_ns == abort_at) begin
          ramp_abort  = 1'b1;
          r_abort_cyc = c;
        end
      end
      if (ramp_done) begin
        r_done++;
        r_done_cyc = c;
        r_to = 1'b0;
        break;
      end
      if (restart && c == 3) ramp_start = 1'b1;
      if (mid_apply && c == 1) begin
        cfg_wr = 1'b1; cfg_addr = sel; cfg_wdata = 7'd33;
      end
      if (mid_apply && c == 2) cfg_apply = 1'b1;
      if (mid_apply && c == 4) chk("mid_apply_slice_keeps_ramp", slice(sel), therm(lo));
    end
    ramp_abort = 1'b0;
    if (r_to) begin
      nvec++; nfail++;
      $display("FAIL ramp_timeout: got no ramp_done within 300 cycles, expected a done pulse");
    end
  endtask

  task automatic illegal_req(input string nm, input logic [3:0] sel, input logic [6:0] lo,
                             input logic [6:0] hi, input logic [6:0] st);
    @(negedge CLK);
    ramp_sel = sel; ramp_lo = lo; ramp_hi = hi; ramp_step = st; ramp_dwell = 16'd1;
    ramp_start = 1'b1;
    @(negedge CLK);
    ramp_start = 1'b0;
    chk({nm, "_err"}, cfg_err, 1'b1);
    chk({nm, "_busy"}, ramp_busy, 1'b0);
    @(negedge CLK);
    chk({nm, "_err_pulse"}, cfg_err, 1'b0);
    chk({nm, "_busy2"}, ramp_busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd4,  7'd10,  7'd64,  1'b0};
    tbl[1] = '{1'b0, 4'd4,  7'd0,   7'd10,  1'b0};
    tbl[2] = '{1'b1, 4'd11, 7'd5,   7'd0,   1'b1};
    tbl[3] = '{1'b0, 4'd11, 7'd0,   7'd0,   1'b0};
    tbl[4] = '{1'b0, 4'd15, 7'd0,   7'd0,   1'b0};
    tbl[5] = '{1'b1, 4'd0,  7'd127, 7'd64,  1'b0};
    tbl[6] = '{1'b0, 4'd0,  7'd0,   7'd127, 1'b0};
    tbl[7] = '{1'b1, 4'd10, 7'd0,   7'd64,  1'b0};
    tbl[8] = '{1'b0, 4'd10, 7'd0,   7'd0,   1'b0};
    tbl[9] = '{1'b0, 4'd3,  7'd0,   7'd64,  1'b0};

    nRST = 1'b0;
    cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; cfg_apply = 0;
    ramp_start = 0; ramp_abort = 0; ramp_sel = 0; ramp_lo = 0; ramp_hi = 0;
    ramp_step = 0; ramp_dwell = 0;

    // reset state
    repeat (3) @(negedge CLK);
    for (int d = 0; d < ND; d++) chk($sformatf("rst_slice%0d", d), slice(d), therm(64));
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_busy", ramp_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_strobe", ramp_strobe, 0);
    chk("rst_done", ramp_done, 0);
    chk("rst_code", ramp_code, 0);
    nRST = 1'b1;

    // config write / readback table
    for (int i = 0; i < 10; i++) begin
      cfg_wr = tbl[i].wr; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
      @(negedge CLK);
      chk($sformatf("tbl%0d_rdata", i), cfg_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].exp_err);
    end
    cfg_wr = 1'b0;

    // writes without apply leave the bus alone
    chk("noapply_slice4", slice(4), therm(64));
    chk("noapply_slice0", slice(0), therm(64));

    // apply with a same-cycle write: apply takes the old shadow (10)
    cfg_apply = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 7'd20;
    @(negedge CLK);
    cfg_apply = 1'b0; cfg_wr = 1'b0;
    chk("apply_k_slice4_unchanged", slice(4), therm(64));
    @(negedge CLK);
    chk("apply_k1_slice4", slice(4), 128'h7FF);
    chk("apply_k1_slice0", slice(0), therm(127));
    chk("apply_k1_slice10", slice(10), 128'h1);
    chk("apply_k1_slice3", slice(3), therm(64));
    repeat (2) @(negedge CLK);
    chk("same_cycle_wr_not_applied", slice(4), therm(10));
    cfg_addr = 4'd4;
    @(negedge CLK);
    chk("readback4_new", cfg_rdata, 20);
    cfg_apply = 1'b1;
    @(negedge CLK);
    cfg_apply = 1'b0;
    @(negedge CLK);
    chk("second_apply_slice4", slice(4), therm(20));

    // ramp sel 2: 0,7,14 with dwell 3, a mid-ramp start must be ignored
    run_ramp(4'd2, 7'd0, 7'd20, 7'd7, 16'd3, 0, 1'b0, 1'b1);
    chk("r1_strobes", r_ns, 3);
    chk("r1_code0", code_at(0), 0);
    chk("r1_code1", code_at(1), 7);
    chk("r1_code2", code_at(2), 14);
    chk("r1_busy_cycles", r_busy, 15);
    chk("r1_no_err", r_err, 0);
    chk("r1_done_busy", ramp_busy, 0);
    @(negedge CLK);
    chk("r1_revert_slice2", slice(2), therm(64));
    chk("r1_done_pulse", ramp_done, 0);

    // ramp near the top code must stop without wrapping
    run_ramp(4'd5, 7'd120, 7'd127, 7'd5, 16'd0, 0, 1'b0, 1'b0);
    chk("r2_strobes", r_ns, 2);
    chk("r2_code0", code_at(0), 120);
    chk("r2_code1", code_at(1), 125);
    chk("r2_busy_cycles", r_busy, 4);
    @(negedge CLK);
    chk("r2_code_holds", ramp_code, 125);
    chk("r2_revert_slice5", slice(5), therm(64));

    // lo == hi is legal: single code
    run_ramp(4'd0, 7'd50, 7'd50, 7'd1, 16'd1, 0, 1'b0, 1'b0);
    chk("r3_strobes", r_ns, 1);
    chk("r3_code0", code_at(0), 50);
    chk("r3_busy_cycles", r_busy, 3);
    @(negedge CLK);
    chk("r3_revert_slice0", slice(0), therm(127));

    // rejected requests
    illegal_req("ill_step0", 4'd1, 7'd0, 7'd10, 7'd0);
    illegal_req("ill_lo_gt_hi", 4'd1, 7'd30, 7'd20, 7'd1);
    illegal_req("ill_sel", 4'd11, 7'd0, 7'd10, 7'd1);

    // abort in second hold, apply issued mid-ramp
    run_ramp(4'd2, 7'd10, 7'd100, 7'd10, 16'd5, 2, 1'b1, 1'b0);
    chk("r4_strobes", r_ns, 2);
    chk("r4_code0", code_at(0), 10);
    chk("r4_code1", code_at(1), 20);
    chk("r4_abort_to_done", r_done_cyc - r_abort_cyc, 1);
    chk("r4_done_cnt", r_done, 1);
    @(negedge CLK);
    chk("r4_apply_after_done_slice2", slice(2), therm(33));

    // reset in the middle of a ramp
    @(negedge CLK);
    ramp_sel = 4'd7; ramp_lo = 7'd0; ramp_hi = 7'd127; ramp_step = 7'd1; ramp_dwell = 16'd2;
    ramp_start = 1'b1;
    @(negedge CLK);
    ramp_start = 1'b0;
    chk("rr_busy_before", ramp_busy, 1);
    repeat (4) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("rr_busy", ramp_busy, 0);
    chk("rr_done", ramp_done, 0);
    chk("rr_code", ramp_code, 0);
    chk("rr_rdata", cfg_rdata, 0);
    chk("rr_slice7", slice(7), therm(64));
    chk("rr_slice4", slice(4), therm(64));
    chk("rr_slice2", slice(2), therm(64));
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        if (ramp_done) dn++;
      end
      nRST = 1'b1;
      cfg_addr = 4'd4;
      @(negedge CLK);
      if (ramp_done) dn++;
      chk("rr_no_done_pulse", dn, 0);
      chk("rr_shadow4_reset", cfg_rdata, 64);
      chk("rr_busy_after", ramp_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
